mux2: RTL and testbench
=======================

Name: mux2

Overview:
- Registered 2:1 word multiplexer: selects operand a or operand b by a one-bit select and presents the result on y one clock later.
- Generic datapath steering primitive, instantiated wherever two same-width buses converge onto one.
- Default width is 8 bits.

Parameters:
- WIDTH, 8, bit width of a, b and y; legal range 1..64.

Ports:
- clk    input   1      rising-edge clock
- rst_n  input   1      asynchronous active-low reset
- a      input   WIDTH  operand selected when s = 0
- b      input   WIDTH  operand selected when s = 1
- s      input   1      select
- y      output  WIDTH  registered selected operand

Behaviour:
- Reset: rst_n low forces y to all-zeros immediately, without waiting for a clock edge. y stays zero while rst_n is low.
- Release: deassertion of rst_n is synchronised externally. The first rising clk edge with rst_n high loads y.
- Select function:
  - s = 0: next y = a.
  - s = 1: next y = b.
- Latency: exactly 1 cycle. The value sampled at rising edge N appears on y after edge N and holds until edge N+1. There is no enable, so y is reloaded every cycle.
- Input changes between edges have no effect on y until the next edge. There is no combinational path from a, b or s to y.
- Unknown select (s = x/z), per bit:
  - where a[i] == b[i] and both are known, y[i] takes that value;
  - otherwise y[i] = x.
  - This is standard conditional-operator merge semantics and must be preserved in simulation. Do not resolve unknown s to a fixed operand.
- Unknown data: an x/z bit on the selected operand propagates to the same bit of y. Bits of the unselected operand never affect y.
- a == b: y = a regardless of s.
- Reset mid-operation: asserting rst_n at any time clears y asynchronously, overriding any pending load.
- Reset and clock edge together: reset wins; y = 0.
- No internal state other than the y register. No handshake, no backpressure.

Decomposition:
- No shared package is required. WIDTH is a local parameter of the block.
- No sub-module. The design is a single always block for the register plus a selection expression.
- An optional combinational mux2_comb helper may be factored out only if other blocks reuse it. It is not required here.

Test Plan:
1. Reset: hold rst_n = 0 with a = 8'hF0, b = 8'h0F, s = 0, clock running -> y = 8'h00 throughout. Assert rst_n asynchronously mid-cycle after y = 8'hF0 -> y = 8'h00 immediately.
2. Select a: rst_n = 1, a = 8'b11110000, b = 8'b00001111, s = 0 -> after next edge y = 8'b11110000.
3. Select b and data change:
   - s = 1 -> y = 8'b00001111 after one edge.
   - then a = 8'b10000000, b = 8'b00000001 -> y = 8'b00000001 after one edge.
   - then s = 0 -> y = 8'b10000000.
4. Latency check: toggle s between edges with no clock edge -> y unchanged until the next rising edge; y always equals the value selected at the previous edge.
5. X-handling:
   - a = b = 8'bxxxxxxxx, s = x -> y = all x.
   - a = b = 8'hA5, s = x -> y = 8'hA5.
   - a = 8'hFF, b = 8'h0F, s = x -> y = 8'bxxxx1111.
6. Width parameter: WIDTH = 1 and WIDTH = 32 instances with random a, b, s over 1000 cycles -> y equals the registered reference model (s ? b : a, 1-cycle delay) every cycle.

Source files
------------

// File: rtl/mux2_pkg.sv
// Shared constants for the registered 2:1 word multiplexer.
package mux2_pkg;

    localparam int unsigned MUX2_DEFAULT_WIDTH = 32'd8;

endpackage : mux2_pkg

// File: rtl/mux2.sv
// Registered 2:1 word multiplexer: y takes a (s = 0) or b (s = 1) one clock after sampling.
// Unknown select keeps conditional-operator merge semantics so x-pessimism stays visible in simulation.
module mux2
    import mux2_pkg::*;
#(
    parameter int unsigned WIDTH = MUX2_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             s,
    output logic [WIDTH-1:0] y
);

    logic [WIDTH-1:0] sel_s;
    logic [WIDTH-1:0] y_r;

    // Selection expression; the ?: form merges a and b bitwise when s is unknown.
    assign sel_s = s ? b : a;

    // Output register with asynchronous clear; reloaded on every rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_r <= {WIDTH{1'b0}};
        end else begin
            y_r <= sel_s;
        end
    end

    assign y = y_r;

endmodule : mux2

// File: tb/tb_mux2.sv
// Self-checking bench for mux2: scoreboard queues hold the value expected after each edge.
module tb_mux2;

    logic        clk;
    logic        rst_n;
    logic [7:0]  a8, b8, y8;
    logic        s8;
    logic [0:0]  a1, b1, y1;
    logic        s1;
    logic [31:0] a32, b32, y32;
    logic        s32;

    logic [7:0]  exp8_q [$];
    logic [0:0]  exp1_q [$];
    logic [31:0] exp32_q [$];

    int checks;
    int failures;

    mux2 #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .s(s8), .y(y8)
    );

    mux2 #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .s(s1), .y(y1)
    );

    mux2 #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .a(a32), .b(b32), .s(s32), .y(y32)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference for the 8-bit instance, including per-bit merge on unknown select.
    function automatic logic [7:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic s);
        logic [7:0] r;
        if (s === 1'b0) begin
            r = a;
        end else if (s === 1'b1) begin
            r = b;
        end else begin
            for (int i = 0; i < 8; i++) begin
                if ((a[i] === b[i]) && !$isunknown(a[i])) r[i] = a[i];
                else                                       r[i] = 1'bx;
            end
        end
        return r;
    endfunction

    task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic s);
        a8 = a;
        b8 = b;
        s8 = s;
        exp8_q.push_back(ref8(a8, b8, s8));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [7:0] exp;
        rst_n = 1'b0;
        a8 = 8'hF0; b8 = 8'h0F; s8 = 1'b0;
        #2;
        checks++;
        if (y8 !== 8'h00) begin
            failures++;
            $display("FAIL reset_async_start: y=%h expected=%h", y8, 8'h00);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (y8 !== 8'h00) begin
                failures++;
                $display("FAIL reset_hold cycle %0d: y=%h expected=%h", i, y8, 8'h00);
            end
        end
        rst_n = 1'b1;
        drive8(8'hF0, 8'h0F, 1'b0);
        tick();
        exp = exp8_q.pop_front();
        checks++;
        if (y8 !== exp) begin
            failures++;
            $display("FAIL reset_release_load: y=%h expected=%h", y8, exp);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (y8 !== 8'h00) begin
            failures++;
            $display("FAIL reset_midcycle: y=%h expected=%h", y8, 8'h00);
        end
        tick();
        checks++;
        if (y8 !== 8'h00) begin
            failures++;
            $display("FAIL reset_over_edge: y=%h expected=%h", y8, 8'h00);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_select();
        logic [7:0] exp;
        logic [7:0] va [4] = '{8'b11110000, 8'b11110000, 8'b10000000, 8'b10000000};
        logic [7:0] vb [4] = '{8'b00001111, 8'b00001111, 8'b00000001, 8'b00000001};
        logic       vs [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic [7:0] want [4] = '{8'b11110000, 8'b00001111, 8'b00000001, 8'b10000000};
        for (int i = 0; i < 4; i++) begin
            drive8(va[i], vb[i], vs[i]);
            tick();
            exp = exp8_q.pop_front();
            checks++;
            if (y8 !== exp || y8 !== want[i]) begin
                failures++;
                $display("FAIL select step %0d: y=%b expected=%b", i, y8, want[i]);
            end
        end
    endtask

    task automatic test_latency();
        logic [7:0] exp;
        drive8(8'h11, 8'h22, 1'b0);
        tick();
        exp = exp8_q.pop_front();
        checks++;
        if (y8 !== exp) begin
            failures++;
            $display("FAIL latency_load: y=%h expected=%h", y8, exp);
        end
        s8 = 1'b1;
        #2;
        checks++;
        if (y8 !== 8'h11) begin
            failures++;
            $display("FAIL latency_s_toggle: y=%h expected=%h", y8, 8'h11);
        end
        s8 = 1'b0; a8 = 8'h33;
        #1;
        s8 = 1'b1;
        #1;
        checks++;
        if (y8 !== 8'h11) begin
            failures++;
            $display("FAIL latency_data_change: y=%h expected=%h", y8, 8'h11);
        end
        exp8_q.push_back(ref8(a8, b8, s8));
        tick();
        exp = exp8_q.pop_front();
        checks++;
        if (y8 !== exp || y8 !== 8'h22) begin
            failures++;
            $display("FAIL latency_next_edge: y=%h expected=%h", y8, 8'h22);
        end
    endtask

    task automatic test_xhandling();
        logic [7:0] exp;
        logic [7:0] va [3] = '{8'bxxxxxxxx, 8'hA5, 8'hFF};
        logic [7:0] vb [3] = '{8'bxxxxxxxx, 8'hA5, 8'h0F};
        for (int i = 0; i < 3; i++) begin
            drive8(va[i], vb[i], 1'bx);
            tick();
            exp = exp8_q.pop_front();
            checks++;
            if (y8 !== exp) begin
                failures++;
                $display("FAIL xsel case %0d: y=%b expected=%b", i, y8, exp);
            end
        end
        checks++;
        if (y8[3:0] !== 4'b1111) begin
            failures++;
            $display("FAIL xsel_known_bits: y=%b expected=xxxx1111", y8);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp;
        for (int i = 0; i < 40; i++) begin
            drive8(8'($urandom), 8'($urandom), 1'($urandom));
            tick();
            exp = exp8_q.pop_front();
            checks++;
            if (y8 !== exp) begin
                failures++;
                $display("FAIL back_to_back cycle %0d: y=%h expected=%h", i, y8, exp);
            end
        end
    endtask

    task automatic test_widths();
        logic [0:0]  e1;
        logic [31:0] e32;
        for (int i = 0; i < 1000; i++) begin
            a1 = 1'($urandom); b1 = 1'($urandom); s1 = 1'($urandom);
            a32 = $urandom; b32 = $urandom; s32 = 1'($urandom);
            exp1_q.push_back((s1 == 1'b1) ? b1 : a1);
            exp32_q.push_back((s32 == 1'b1) ? b32 : a32);
            tick();
            e1 = exp1_q.pop_front();
            e32 = exp32_q.pop_front();
            checks++;
            if (y1 !== e1) begin
                failures++;
                $display("FAIL width1 cycle %0d: y=%b expected=%b", i, y1, e1);
            end
            checks++;
            if (y32 !== e32) begin
                failures++;
                $display("FAIL width32 cycle %0d: y=%h expected=%h", i, y32, e32);
            end
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        a1 = 1'b0; b1 = 1'b0; s1 = 1'b0;
        a32 = 32'h0; b32 = 32'h0; s32 = 1'b0;
        test_reset();
        test_select();
        test_latency();
        test_xhandling();
        test_back_to_back();
        test_widths();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mux2
